// File: rtl/booth_mult_ctrl.sv
// Radix-2 Booth sequencer driving an external 65-bit product register
// ({product hi, multiplier, Booth bit}); one add/shift step per clock.
module booth_mult_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clock,
  input  logic               ctrl_reset,
  input  logic               ctrl_MULT,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  input  logic [2*WIDTH:0]   prod_q,
  output logic [2*WIDTH:0]   prod_d,
  output logic               prod_we,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_exception,
  output logic               data_resultRDY,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           stateReg;
  logic [CNT_W-1:0] cntReg;
  logic [WIDTH-1:0] aLatReg;
  logic             busyReg;
  logic             rdyReg;

  logic [1:0]       boothSel;
  logic [WIDTH:0]   hiExt;
  logic [WIDTH:0]   aExt;
  logic [WIDTH:0]   addend;
  logic             carryIn;
  logic [WIDTH:0]   stepSum;
  logic [2*WIDTH:0] stepNext;
  logic [2*WIDTH:0] loadNext;
  logic [WIDTH-1:0] signDiff;

  // Upper word is widened by one bit so +/- the most negative multiplicand
  // cannot overflow; the shift then drops the extra bit back into place.
  assign boothSel = prod_q[1:0];
  assign hiExt    = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
  assign aExt     = {aLatReg[WIDTH-1], aLatReg};

  always_comb begin
    addend  = '0;
    carryIn = 1'b0;
    case (boothSel)
      2'b01:   addend = aExt;
      2'b10: begin
        addend  = ~aExt;
        carryIn = 1'b1;
      end
      default: addend = '0;
    endcase
  end

  assign stepSum  = hiExt + addend + {{WIDTH{1'b0}}, carryIn};
  assign stepNext = {stepSum, prod_q[WIDTH:1]};
  assign loadNext = {{WIDTH{1'b0}}, data_operandB, 1'b0};

  // The write port must be valid before the edge that commits it, so these
  // are decoded from the current state and the start request.
  assign prod_d  = ctrl_MULT ? loadNext : stepNext;
  assign prod_we = !ctrl_reset && (ctrl_MULT || (stateReg == RUN));

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      aLatReg  <= '0;
      busyReg  <= 1'b0;
      rdyReg   <= 1'b0;
    end else if (ctrl_MULT) begin
      stateReg <= RUN;
      cntReg   <= '0;
      aLatReg  <= data_operandA;
      busyReg  <= 1'b1;
      rdyReg   <= 1'b0;
    end else begin
      case (stateReg)
        RUN: begin
          cntReg <= cntReg + 1'b1;
          if (cntReg == CNT_W'(WIDTH - 1)) begin
            stateReg <= DONE;
            busyReg  <= 1'b0;
            rdyReg   <= 1'b1;
          end
        end
        DONE: begin
          stateReg <= IDLE;
          rdyReg   <= 1'b0;
        end
        default: begin
          stateReg <= IDLE;
          busyReg  <= 1'b0;
          rdyReg   <= 1'b0;
        end
      endcase
    end
  end

  // Overflow: any upper product bit disagreeing with the result's sign bit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : gSign
      assign signDiff[gi] = prod_q[WIDTH+1+gi] ^ prod_q[WIDTH];
    end
  endgenerate

  assign data_result    = prod_q[WIDTH:1];
  assign data_exception = |signDiff;
  assign data_resultRDY = rdyReg;
  assign busy           = busyReg;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Directed and random checks of booth_mult_ctrl with a behavioural product
// register; inputs change and outputs are sampled on the falling edge.
module tb_booth_mult_ctrl;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [64:0] prod_q;
  logic [64:0] prod_d;
  logic        prod_we;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int nChecks = 0;
  int nErrs   = 0;

  always #5 clock = ~clock;

  booth_mult_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .ctrl_reset     (ctrl_reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .prod_q         (prod_q),
    .prod_d         (prod_d),
    .prod_we        (prod_we),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always_ff @(posedge clock) begin
    if (ctrl_reset)   prod_q <= '0;
    else if (prod_we) prod_q <= prod_d;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation from an idle-ish state; operands are scrambled after
  // the start edge to show they are not re-sampled.
  task automatic doMult(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expRes, input logic expExc);
    logic [34:0] busyM;
    logic [34:0] rdyM;
    logic [31:0] res33;
    logic [31:0] res34;
    logic        exc33;
    logic        we33;
    busyM = '0;
    rdyM  = '0;
    res33 = '0;
    res34 = '0;
    exc33 = 1'b0;
    we33  = 1'b1;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    for (int cyc = 1; cyc <= 34; cyc++) begin
      @(negedge clock);
      busyM[cyc] = busy;
      rdyM[cyc]  = data_resultRDY;
      if (cyc == 33) begin
        res33 = data_result;
        exc33 = data_exception;
        we33  = prod_we;
      end
      if (cyc == 34) res34 = data_result;
      if (cyc == 1) begin
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
      end
    end
    check({tag, ".busy"}, 64'(busyM), 64'h1_FFFF_FFFE);
    check({tag, ".rdy"},  64'(rdyM),  64'h2_0000_0000);
    check({tag, ".res"},  64'(res33), 64'(expRes));
    check({tag, ".exc"},  64'(exc33), 64'(expExc));
    check({tag, ".we"},   64'(we33),  64'h0);
    check({tag, ".hold"}, 64'(res34), 64'(expRes));
  endtask

  initial begin
    logic [45:0] rdyM;
    logic [45:0] busyM;
    logic [45:0] expM;
    logic [31:0] resAt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    logic        expExc;
    longint      p;

    ctrl_reset    = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    ctrl_reset = 1'b0;
    @(negedge clock);
    check("rst.busy", 64'(busy), 64'h0);
    check("rst.rdy",  64'(data_resultRDY), 64'h0);
    check("rst.we",   64'(prod_we), 64'h0);
    check("rst.res",  64'(data_result), 64'h0);
    check("rst.exc",  64'(data_exception), 64'h0);

    doMult("3x4",      32'd3,          32'd4,          32'h0000_000C, 1'b0);
    doMult("m5x7",     32'hFFFF_FFFB,  32'd7,          32'hFFFF_FFDD, 1'b0);
    doMult("minx1",    32'h8000_0000,  32'd1,          32'h8000_0000, 1'b0);
    doMult("big",      32'h0001_0000,  32'h0001_0000,  32'h0000_0000, 1'b1);
    doMult("minxm1",   32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1);
    doMult("minxmin",  32'h8000_0000,  32'h8000_0000,  32'h0000_0000, 1'b1);

    // Restart at cycle 10 must suppress the first ready entirely.
    rdyM  = '0;
    resAt = '0;
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    ctrl_MULT     = 1'b1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clock);
      rdyM[cyc] = data_resultRDY;
      if (cyc == 43) resAt = data_result;
      ctrl_MULT = (cyc == 10);
      if (cyc == 10) begin
        data_operandA = 32'd6;
        data_operandB = 32'hFFFF_FFFE;
      end
    end
    expM = '0;
    expM[43] = 1'b1;
    check("abort.rdy", 64'(rdyM), 64'(expM));
    check("abort.res", 64'(resAt), 64'hFFFF_FFF4);

    // Reset in cycle 15 of a 7x7 multiply.
    rdyM  = '0;
    busyM = '0;
    data_operandA = 32'd7;
    data_operandB = 32'd7;
    ctrl_MULT     = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clock);
      rdyM[cyc]  = data_resultRDY;
      busyM[cyc] = busy;
      ctrl_MULT  = 1'b0;
      ctrl_reset = (cyc == 15);
    end
    expM = '0;
    for (int i = 1; i <= 15; i++) expM[i] = 1'b1;
    check("rstmid.busy", 64'(busyM), 64'(expM));
    check("rstmid.rdy",  64'(rdyM), 64'h0);
    check("rstmid.res",  64'(data_result), 64'h0);
    check("rstmid.exc",  64'(data_exception), 64'h0);
    doMult("after_rst", 32'd7, 32'd7, 32'd49, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) a = {{28{a[3]}}, a[3:0]};
      if (i % 5 == 0) b = {{20{b[11]}}, b[11:0]};
      p = longint'(signed'(a)) * longint'(signed'(b));
      expRes = p[31:0];
      expExc = (p != {{32{p[31]}}, p[31:0]});
      doMult("rnd", a, b, expRes, expExc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrs);
    $finish;
  end

endmodule
